compl_serial: RTL and testbench

Digit-serial multi-digit complementer for the arithmetic path. It takes an operand of `DIGITS` nibbles and returns either its diminished-radix complement (9's in BCD, 15's in binary) or its radix complement (10's in BCD, 16's in binary). Each nibble is processed per clock, least-significant digit first, with a carry chain between digits. It replaces per-nibble combinational complementing wherever a full-word complement with carry propagation is needed before the adder.

---
 rtl/compl_serial.sv | 183 ++++++++++++++++++
 tb/tb_compl_serial.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/compl_serial.sv
// compl_serial: digit-serial multi-digit complementer.
//   Produces the diminished-radix complement (9's BCD / 15's binary) or the
//   radix complement (10's BCD / 16's binary) of a DIGITS-nibble operand.
//   The operand is processed one nibble per clock, least-significant digit
//   first, with a carry rippling from digit to digit.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request; accepted in IDLE or DONE
//   din    - operand, digit i at [4i+3:4i]
//   bcd    - 1 = BCD, 0 = binary (sampled with start)
//   radix  - 0 = diminished, 1 = radix complement (sampled with start)
//   busy   - high while digits are processed (DIGITS cycles)
//   done   - one-cycle completion pulse
//   dout   - complemented result, held until the next completion
//   cout   - carry out of the most-significant digit
//   err    - some BCD digit was greater than 9
module compl_serial #(
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  bcd,
  input  logic                  radix,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   dout,
  output logic                  cout,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One digit step. Returns {digit_err, carry_out, result_digit}.
  function automatic logic [5:0] digit_op(input logic [3:0] d,
                                          input logic       c,
                                          input logic       is_bcd);
    logic [4:0] t;
    logic [5:0] res;
    t   = 5'd0;
    res = 6'd0;
    if (!is_bcd) begin
      t   = 5'd15 - {1'b0, d} + {4'd0, c};
      res = {1'b0, t};
    end else if (d > 4'd9) begin
      // Invalid BCD digit: zero result, carry chain broken, flag error.
      res = {1'b1, 1'b0, 4'd0};
    end else begin
      t = 5'd9 - {1'b0, d} + {4'd0, c};
      if (t > 5'd9) begin
        res = {1'b0, 1'b1, t[3:0] - 4'd10};
      end else begin
        res = {1'b0, 1'b0, t[3:0]};
      end
    end
    return res;
  endfunction

  state_t              r_state;
  state_t              w_next_state;
  logic [IDX_W-1:0]    r_idx;
  logic                r_carry;
  logic                r_err_acc;
  logic                r_bcd;
  logic [W-1:0]        r_din;
  logic [W-1:0]        r_acc;
  logic                r_busy;
  logic                r_done;
  logic [W-1:0]        r_dout;
  logic                r_cout;
  logic                r_err;

  logic                w_accept;
  logic                w_last;
  logic                w_busy_next;
  logic                w_done_next;
  logic [IDX_W+1:0]    w_base;
  logic [3:0]          w_digit;
  logic [5:0]          w_dig;
  logic [W-1:0]        w_acc_next;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_idx == LAST_IDX);
  assign w_base   = {r_idx, 2'b00};
  assign w_digit  = r_din[w_base +: 4];
  assign w_dig    = digit_op(w_digit, r_carry, r_bcd);

  // Holding register with the current result digit merged in.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[w_base +: 4] = w_dig[3:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; DONE accepts start exactly like IDLE.
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:  w_next_state = start ? S_RUN : S_IDLE;
      S_RUN:   w_next_state = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so busy/done come out of flops.
  always_comb begin
    w_busy_next = 1'b0;
    w_done_next = 1'b0;
    case (w_next_state)
      S_RUN:   w_busy_next = 1'b1;
      S_DONE:  w_done_next = 1'b1;
      default: begin
        w_busy_next = 1'b0;
        w_done_next = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, digit stepping and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_err_acc <= 1'b0;
      r_bcd     <= 1'b0;
      r_din     <= '0;
      r_acc     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dout    <= '0;
      r_cout    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      r_done <= w_done_next;
      if (w_accept) begin
        r_din     <= din;
        r_bcd     <= bcd;
        r_idx     <= '0;
        r_carry   <= radix;
        r_err_acc <= 1'b0;
        r_acc     <= '0;
      end else if (r_state == S_RUN) begin
        r_acc     <= w_acc_next;
        r_carry   <= w_dig[4];
        r_err_acc <= r_err_acc | w_dig[5];
        r_idx     <= r_idx + IDX_W'(1);
        // Publish only on the final digit so dout never shows a partial word.
        if (w_last) begin
          r_dout <= w_acc_next;
          r_cout <= w_dig[4];
          r_err  <= r_err_acc | w_dig[5];
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dout = r_dout;
  assign cout = r_cout;
  assign err  = r_err;

endmodule

// File: tb/tb_compl_serial.sv
module tb_compl_serial;
  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] din;
  logic        bcd;
  logic        radix;
  logic        busy;
  logic        done;
  logic [15:0] dout;
  logic        cout;
  logic        err;

  int total = 0;
  int bad   = 0;

  compl_serial #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .bcd(bcd),
    .radix(radix), .busy(busy), .done(done), .dout(dout), .cout(cout),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic        bcd;
    logic        radix;
    logic [15:0] dout;
    logic        cout;
    logic        err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: whole-number complement of each run of valid digits. An
  // invalid BCD digit yields 0 and restarts the chain with carry 0.
  function automatic void model(input logic [15:0] d, input logic b, input logic r,
                                output logic [15:0] o, output logic co, output logic e);
    int base, c, s, n, m, res;
    logic inval;
    base = b ? 10 : 16;
    c = r ? 1 : 0;
    s = 0;
    o = 16'h0000;
    e = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      inval = (i < 4) && b && (d[4*i +: 4] > 4'd9);
      if (i == 4 || inval) begin
        n = 0;
        m = 1;
        for (int j = i - 1; j >= s; j--) n = n * base + int'(d[4*j +: 4]);
        for (int j = s; j < i; j++) m = m * base;
        res = (m - 1 - n) + c;
        c = (res >= m) ? 1 : 0;
        res = res % m;
        for (int j = s; j < i; j++) begin
          o[4*j +: 4] = 4'(res % base);
          res = res / base;
        end
        if (inval) begin
          e = 1'b1;
          c = 0;
          s = i + 1;
        end
      end
    end
    co = (c != 0);
  endfunction

  // Issue one operation and wait (bounded) for done; checks latency.
  task automatic run_op(input logic [15:0] d, input logic b, input logic r, input bit scramble);
    int n;
    din = d; bcd = b; radix = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) begin
      bcd = ~b; radix = ~r; din = 16'($urandom);
    end
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, DIGITS);
    chk("busy_with_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [15:0] ed, rd;
    logic        ec, ee, rb, rr;
    int          dq[$];
    int          ndone;

    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [15:0] ed, rd;
    logic        ec, ee, rb, rr;
    int          dq[$];
    int          ndone;

    rst_n = 1'b0; start = 1'b0; din = 16'h0000; bcd = 1'b0; radix = 1'b0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_dout", {16'd0, dout}, 32'd0);
    chk("reset_cout_err", {30'd0, cout, err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    vecs.push_back('{16'h1234, 1'b1, 1'b0, 16'h8765, 1'b0, 1'b0});
    vecs.push_back('{16'h1230, 1'b1, 1'b1, 16'h8770, 1'b0, 1'b0});
    vecs.push_back('{16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0});
    vecs.push_back('{16'h00F0, 1'b0, 1'b0, 16'hFF0F, 1'b0, 1'b0});
    vecs.push_back('{16'h12A4, 1'b1, 1'b0, 16'h8705, 1'b0, 1'b1});
    vecs.push_back('{16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h9999, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{16'h0001, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0});
    vecs.push_back('{16'hF000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1});
    vecs.push_back('{16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{16'h5000, 1'b0, 1'b1, 16'hB000, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].din, vecs[i].bcd, vecs[i].radix, 1'b0);
      chk($sformatf("vec%0d_dout", i), {16'd0, dout}, {16'd0, vecs[i].dout});
      chk($sformatf("vec%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].cout});
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("vec%0d_hold", i), {15'd0, dout, cout}, {15'd0, vecs[i].dout, vecs[i].cout});
    end

    // Randomised operations; mode inputs and operand scrambled during RUN.
    for (int i = 0; i < 60; i++) begin
      rb = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rd = 16'($urandom);
      if (rb) begin
        for (int k = 0; k < 4; k++) begin
          if ($urandom_range(0, 9) == 0) rd[4*k +: 4] = 4'($urandom_range(10, 15));
          else                           rd[4*k +: 4] = 4'($urandom_range(0, 9));
        end
      end
      model(rd, rb, rr, ed, ec, ee);
      run_op(rd, rb, rr, 1'b1);
      chk($sformatf("rnd%0d_dout", i), {16'd0, dout}, {16'd0, ed});
      chk($sformatf("rnd%0d_cout_err", i), {30'd0, cout, err}, {30'd0, ec, ee});
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back: start held for 12 edges -> accepts at edges 1, 6, 11.
    din = 16'h1234; bcd = 1'b1; radix = 1'b0; start = 1'b1;
    dq.delete();
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 12) start = 1'b0;
      if (done) dq.push_back(c);
      chk("b2b_busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) chk("b2b_dout", {16'd0, dout}, 32'h0000_8765);
    end
    chk("b2b_count", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("b2b_first", dq[0], 5);
      chk("b2b_gap1", dq[1] - dq[0], 5);
      chk("b2b_gap2", dq[2] - dq[1], 5);
    end

    // start pulses during RUN must be ignored.
    repeat (2) @(posedge clk);
    #1;
    din = 16'h0001; bcd = 1'b0; radix = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0;
    dq.delete();
    for (int k = 1; k <= 12; k++) begin
      start = (k == 2 || k == 3);
      @(posedge clk); #1;
      if (done) dq.push_back(k);
      if (k < 4) chk("run_ignore_busy", {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    chk("run_ignore_count", dq.size(), 1);
    if (dq.size() == 1) chk("run_ignore_pos", dq[0], 4);
    chk("run_ignore_dout", {16'd0, dout}, 32'h0000_FFFF);

    // Reset two cycles into RUN.
    run_op(16'h12A4, 1'b1, 1'b0, 1'b0);
    chk("pre_reset_err", {31'd0, err}, 32'd1);
    @(posedge clk); #1;
    din = 16'h0000; bcd = 1'b1; radix = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst_cout_err", {30'd0, cout, err}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    chk("rst_hold_dout", {16'd0, dout}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
